// File: rtl/lift_motion_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lift_motion_ctrl_if
// Description : Command/status bundle between the lift FSM (master) and the
//               motion controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lift_motion_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic       door_hold;
  logic       motor_up;
  logic       motor_dn;
  logic       door_open;
  logic [1:0] floor;
  logic       arrive;
  logic       cmd_err;
  logic       busy;

  // Lift FSM side: issues commands, observes motion status
  modport master (
    output cmd_valid, cmd, door_hold,
    input  cmd_ready, motor_up, motor_dn, door_open, floor, arrive, cmd_err, busy
  );

  // Motion controller side
  modport slave (
    input  cmd_valid, cmd, door_hold,
    output cmd_ready, motor_up, motor_dn, door_open, floor, arrive, cmd_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/lift_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lift_motion_ctrl
// Description : Turns UP/DOWN/STAY move commands into timed motor drive, a
//               floor position (floors 1..4 as 0..3) and a door open/close
//               cycle; back-pressures the FSM until the door has closed.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_motion_ctrl #(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int CNT_W         = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  lift_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOOR  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  localparam logic [1:0]       c_cmd_up     = 2'b00;
  localparam logic [1:0]       c_cmd_dn     = 2'b01;
  localparam logic [1:0]       c_cmd_stay   = 2'b10;
  localparam logic [1:0]       c_top_floor  = 2'd3;
  localparam logic [1:0]       c_bot_floor  = 2'd0;
  localparam logic [CNT_W-1:0] c_travel_ld  = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_door_ld    = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_floor;
  logic             r_motor_up;
  logic             r_motor_dn;
  logic             r_door_open;
  logic             r_arrive;
  logic             r_cmd_err;
  logic             w_idle;

  // Only IDLE accepts commands; everything else is back-pressured
  assign w_idle        = (r_state == IDLE);
  assign bus.cmd_ready = w_idle;
  assign bus.busy      = ~w_idle;
  assign bus.motor_up  = r_motor_up;
  assign bus.motor_dn  = r_motor_dn;
  assign bus.door_open = r_door_open;
  assign bus.floor     = r_floor;
  assign bus.arrive    = r_arrive;
  assign bus.cmd_err   = r_cmd_err;

  // Motion FSM: one shared down-counter times both the travel and the door phases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_floor     <= 2'd0;
      r_motor_up  <= 1'b0;
      r_motor_dn  <= 1'b0;
      r_door_open <= 1'b0;
      r_arrive    <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below
      r_arrive  <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd)
              c_cmd_up: begin
                if (r_floor != c_top_floor) begin
                  r_state    <= MOVE;
                  r_cnt      <= c_travel_ld;
                  r_motor_up <= 1'b1;
                end else begin
                  r_cmd_err <= 1'b1;
                end
              end
              c_cmd_dn: begin
                if (r_floor != c_bot_floor) begin
                  r_state    <= MOVE;
                  r_cnt      <= c_travel_ld;
                  r_motor_dn <= 1'b1;
                end else begin
                  r_cmd_err <= 1'b1;
                end
              end
              c_cmd_stay: begin
                r_state     <= DOOR;
                r_cnt       <= c_door_ld;
                r_door_open <= 1'b1;
                r_arrive    <= 1'b1;
              end
              default: r_cmd_err <= 1'b1;
            endcase
          end
        end
        MOVE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_one;
          end else begin
            // The active motor flag doubles as the direction of travel
            if (r_motor_up) begin
              r_floor <= r_floor + 2'd1;
            end else begin
              r_floor <= r_floor - 2'd1;
            end
            r_motor_up  <= 1'b0;
            r_motor_dn  <= 1'b0;
            r_state     <= DOOR;
            r_cnt       <= c_door_ld;
            r_door_open <= 1'b1;
            r_arrive    <= 1'b1;
          end
        end
        DOOR: begin
          if (bus.door_hold) begin
            r_cnt <= c_door_ld;
          end else if (r_cnt == '0) begin
            r_state     <= CLOSE;
            r_door_open <= 1'b0;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        CLOSE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
